// File: rtl/iir_cascade_tdm.sv
// Cascade of SECTIONS biquad sections sharing one multiplier in 3-cycle slots.
// Coefficients are loadable between samples; samples use a valid/ready handshake.
module iir_cascade_tdm #(
  parameter int WORD_SIZE  = 16,
  parameter int ACCUM_SIZE = 24,
  parameter int GUARD_BITS = 4,
  parameter int COEF_W     = 18,
  parameter int SECTIONS   = 4
) (
  input  logic                        inClock,
  input  logic                        reset,
  input  logic signed [WORD_SIZE-1:0] inData,
  input  logic                        inValid,
  output logic                        inReady,
  output logic signed [WORD_SIZE-1:0] outData,
  output logic                        outValid,
  input  logic                        stateClear,
  input  logic                        cfgWrite,
  input  logic [5:0]                  cfgAddr,
  input  logic [COEF_W-1:0]           cfgData,
  output logic                        cfgReady
);

  localparam int S      = ACCUM_SIZE - WORD_SIZE - GUARD_BITS;
  localparam int SUM_W  = ACCUM_SIZE + 2;
  localparam int PROD_W = COEF_W + ACCUM_SIZE;
  localparam int FRAC   = COEF_W - 2;
  localparam int ROUND  = 1 << (S - 1);
  localparam logic [3:0] LAST_K     = 4'(SECTIONS - 1);
  localparam logic [5:0] CTRL_RESET = 6'b100000;

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t                         state;
  logic [3:0]                     k_reg;
  logic [1:0]                     phase_reg;
  logic signed [ACCUM_SIZE-1:0]   x_reg;
  logic signed [ACCUM_SIZE-1:0]   w_reg;
  logic signed [SUM_W-1:0]        acc_reg;
  logic                           clear_pend_reg;
  logic                           pend_valid_reg;
  logic [5:0]                     pend_addr_reg;
  logic [COEF_W-1:0]              pend_data_reg;

  logic signed [COEF_W-1:0]       a1_all [SECTIONS];
  logic signed [COEF_W-1:0]       a2_all [SECTIONS];
  logic signed [COEF_W-1:0]       b1_all [SECTIONS];
  logic [5:0]                     ctrl_all [SECTIONS];
  logic signed [ACCUM_SIZE-1:0]   w1_all [SECTIONS];
  logic signed [ACCUM_SIZE-1:0]   w2_all [SECTIONS];

  logic signed [COEF_W-1:0]       sel_a1, sel_a2, sel_b1;
  logic [5:0]                     sel_ctrl;
  logic signed [ACCUM_SIZE-1:0]   sel_w1, sel_w2;

  logic signed [COEF_W-1:0]       mul_coef;
  logic signed [ACCUM_SIZE-1:0]   mul_state;
  logic signed [PROD_W-1:0]       prod;
  logic signed [SUM_W-1:0]        prod_sh;

  logic signed [ACCUM_SIZE-1:0]   xs;
  logic signed [SUM_W-1:0]        xs_ext, w_ext, w2_ext;
  logic signed [SUM_W-1:0]        acc_next, w_sum, y_sum;
  logic signed [ACCUM_SIZE-1:0]   w_sat, y_sat;

  logic signed [ACCUM_SIZE:0]     out_sum, out_sh;
  logic signed [WORD_SIZE-1:0]    out_word;

  logic                           wr_direct, wr_commit, wr_en, clr_now;
  logic [5:0]                     wr_addr;
  logic [COEF_W-1:0]              wr_data;

  function automatic logic signed [ACCUM_SIZE-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
    if (&v[SUM_W-1:ACCUM_SIZE-1] || ~|v[SUM_W-1:ACCUM_SIZE-1])
      return v[ACCUM_SIZE-1:0];
    else if (v[SUM_W-1])
      return {1'b1, {(ACCUM_SIZE-1){1'b0}}};
    else
      return {1'b0, {(ACCUM_SIZE-1){1'b1}}};
  endfunction

  assign inReady  = (state == IDLE);
  assign cfgReady = (state == IDLE);

  // A write arriving together with an accepted sample is parked until that
  // sample has left, so the sample still runs on the old coefficients.
  assign wr_direct = (state == IDLE) && cfgWrite && !inValid;
  assign wr_commit = (state == OUT) && pend_valid_reg;
  assign wr_en     = wr_direct || wr_commit;
  assign wr_addr   = wr_commit ? pend_addr_reg : cfgAddr;
  assign wr_data   = wr_commit ? pend_data_reg : cfgData;

  assign clr_now = ((state == IDLE) && stateClear) ||
                   ((state == OUT) && (clear_pend_reg || stateClear));

  genvar gi;
  generate
    for (gi = 0; gi < SECTIONS; gi++) begin : g_sec
      logic signed [COEF_W-1:0]     a1_reg, a2_reg, b1_reg;
      logic [5:0]                   ctrl_reg;
      logic signed [ACCUM_SIZE-1:0] w1_reg, w2_reg;
      logic                         sec_wr, sec_upd;

      assign sec_wr  = wr_en && (wr_addr[5:2] == 4'(gi));
      assign sec_upd = (state == RUN) && (phase_reg == 2'd2) &&
                       (k_reg == 4'(gi)) && !ctrl_reg[5];

      always_ff @(posedge inClock or negedge reset) begin
        if (!reset) begin
          a1_reg   <= '0;
          a2_reg   <= '0;
          b1_reg   <= '0;
          ctrl_reg <= CTRL_RESET;
          w1_reg   <= '0;
          w2_reg   <= '0;
        end else begin
          if (sec_wr) begin
            case (wr_addr[1:0])
              2'd0:    a1_reg   <= wr_data;
              2'd1:    a2_reg   <= wr_data;
              2'd2:    b1_reg   <= wr_data;
              default: ctrl_reg <= wr_data[5:0];
            endcase
          end
          if (clr_now) begin
            w1_reg <= '0;
            w2_reg <= '0;
          end else if (sec_upd) begin
            w2_reg <= w1_reg;
            w1_reg <= w_reg;
          end
        end
      end

      assign a1_all[gi]   = a1_reg;
      assign a2_all[gi]   = a2_reg;
      assign b1_all[gi]   = b1_reg;
      assign ctrl_all[gi] = ctrl_reg;
      assign w1_all[gi]   = w1_reg;
      assign w2_all[gi]   = w2_reg;
    end
  endgenerate

  always_comb begin
    sel_a1   = '0;
    sel_a2   = '0;
    sel_b1   = '0;
    sel_ctrl = CTRL_RESET;
    sel_w1   = '0;
    sel_w2   = '0;
    for (int i = 0; i < SECTIONS; i++) begin
      if (k_reg == 4'(i)) begin
        sel_a1   = a1_all[i];
        sel_a2   = a2_all[i];
        sel_b1   = b1_all[i];
        sel_ctrl = ctrl_all[i];
        sel_w1   = w1_all[i];
        sel_w2   = w2_all[i];
      end
    end
  end

  // The single shared multiplier: operands rotate with the phase.
  always_comb begin
    case (phase_reg)
      2'd0: begin
        mul_coef  = sel_a1;
        mul_state = sel_w1;
      end
      2'd1: begin
        mul_coef  = sel_a2;
        mul_state = sel_w2;
      end
      default: begin
        mul_coef  = sel_b1;
        mul_state = sel_w1;
      end
    endcase
  end

  assign prod    = mul_coef * mul_state;
  assign prod_sh = SUM_W'(prod >>> FRAC);

  assign xs     = x_reg >>> sel_ctrl[3:0];
  assign xs_ext = {{(SUM_W-ACCUM_SIZE){xs[ACCUM_SIZE-1]}}, xs};
  assign w_ext  = {{(SUM_W-ACCUM_SIZE){w_reg[ACCUM_SIZE-1]}}, w_reg};
  assign w2_ext = {{(SUM_W-ACCUM_SIZE){sel_w2[ACCUM_SIZE-1]}}, sel_w2};

  assign acc_next = xs_ext - prod_sh;
  assign w_sum    = acc_reg - prod_sh;
  assign w_sat    = sat_acc(w_sum);
  assign y_sum    = sel_ctrl[4] ? (w_ext + prod_sh - w2_ext) : (w_ext + prod_sh + w2_ext);
  assign y_sat    = sat_acc(y_sum);

  assign out_sum = {x_reg[ACCUM_SIZE-1], x_reg} + (ACCUM_SIZE+1)'(ROUND);
  assign out_sh  = out_sum >>> S;

  always_comb begin
    if (&out_sh[ACCUM_SIZE:WORD_SIZE-1] || ~|out_sh[ACCUM_SIZE:WORD_SIZE-1])
      out_word = out_sh[WORD_SIZE-1:0];
    else if (out_sh[ACCUM_SIZE])
      out_word = {1'b1, {(WORD_SIZE-1){1'b0}}};
    else
      out_word = {1'b0, {(WORD_SIZE-1){1'b1}}};
  end

  always_ff @(posedge inClock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      k_reg          <= '0;
      phase_reg      <= '0;
      x_reg          <= '0;
      w_reg          <= '0;
      acc_reg        <= '0;
      outData        <= '0;
      outValid       <= 1'b0;
      clear_pend_reg <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_addr_reg  <= '0;
      pend_data_reg  <= '0;
    end else begin
      outValid <= 1'b0;
      case (state)
        IDLE: begin
          if (inValid) begin
            x_reg     <= {{(ACCUM_SIZE-WORD_SIZE){inData[WORD_SIZE-1]}}, inData} << S;
            k_reg     <= '0;
            phase_reg <= '0;
            state     <= RUN;
            if (cfgWrite) begin
              pend_valid_reg <= 1'b1;
              pend_addr_reg  <= cfgAddr;
              pend_data_reg  <= cfgData;
            end
          end
        end
        RUN: begin
          if (stateClear)
            clear_pend_reg <= 1'b1;
          case (phase_reg)
            2'd0: begin
              acc_reg   <= acc_next;
              phase_reg <= 2'd1;
            end
            2'd1: begin
              w_reg     <= w_sat;
              phase_reg <= 2'd2;
            end
            default: begin
              phase_reg <= 2'd0;
              if (!sel_ctrl[5])
                x_reg <= y_sat;
              if (k_reg == LAST_K)
                state <= OUT;
              else
                k_reg <= k_reg + 4'd1;
            end
          endcase
        end
        OUT: begin
          outData        <= out_word;
          outValid       <= 1'b1;
          state          <= IDLE;
          clear_pend_reg <= 1'b0;
          pend_valid_reg <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_cascade_tdm.sv
// Bench for iir_cascade_tdm: directed vector table, mid-run corner sequences
// and randomized samples against a per-sample reference model.
module tb_iir_cascade_tdm;
  localparam int NS = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               state_clear = 1'b0;
  logic               cfg_write = 1'b0;
  logic [5:0]         cfg_addr = '0;
  logic [17:0]        cfg_data = '0;
  logic               cfg_ready;

  iir_cascade_tdm dut (
    .inClock(clk), .reset(rst_n), .inData(in_data), .inValid(in_valid),
    .inReady(in_ready), .outData(out_data), .outValid(out_valid),
    .stateClear(state_clear), .cfgWrite(cfg_write), .cfgAddr(cfg_addr),
    .cfgData(cfg_data), .cfgReady(cfg_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int     m_a1 [NS];
  int     m_a2 [NS];
  int     m_b1 [NS];
  int     m_ctrl [NS];
  longint m_w1 [NS];
  longint m_w2 [NS];

  typedef struct {
    int grp;
    int din;
    int exp;
  } vec_t;
  vec_t tbl [17];

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic longint wrap_sum(input longint v);
    longint m;
    m = v & ((longint'(1) <<< 26) - 1);
    if (m >= (longint'(1) <<< 25)) m = m - (longint'(1) <<< 26);
    return m;
  endfunction

  function automatic longint sat_to(input longint v, input int bits);
    longint hi, lo;
    hi = (longint'(1) <<< (bits - 1)) - 1;
    lo = -(longint'(1) <<< (bits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int sx18(input int v);
    return (v >= 131072) ? v - 262144 : v;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < NS; s++) begin
      m_w1[s] = 0;
      m_w2[s] = 0;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_a1[s] = 0; m_a2[s] = 0; m_b1[s] = 0; m_ctrl[s] = 32;
    end
    model_clear();
  endtask

  // Whole-sample reference: every section evaluated in one pass.
  task automatic model_step(input int din, output int dout);
    longint x, xs, acc, w, y, p;
    x = longint'(din) * 16;
    for (int s = 0; s < NS; s++) begin
      if ((m_ctrl[s] & 32) == 0) begin
        xs  = x >>> (m_ctrl[s] & 15);
        acc = wrap_sum(xs - ((longint'(m_a1[s]) * m_w1[s]) >>> 16));
        w   = sat_to(wrap_sum(acc - ((longint'(m_a2[s]) * m_w2[s]) >>> 16)), 24);
        p   = (longint'(m_b1[s]) * m_w1[s]) >>> 16;
        if ((m_ctrl[s] & 16) != 0) y = w + p - m_w2[s];
        else y = w + p + m_w2[s];
        y = sat_to(wrap_sum(y), 24);
        m_w2[s] = m_w1[s];
        m_w1[s] = w;
        x = y;
      end
    end
    dout = int'(sat_to((x + 8) >>> 4, 16));
  endtask

  task automatic cfg_wr(input int sec, input int field, input int data);
    @(negedge clk);
    cfg_write = 1'b1;
    cfg_addr  = 6'((sec << 2) | field);
    cfg_data  = 18'(data);
    @(negedge clk);
    cfg_write = 1'b0;
    if (sec < NS) begin
      case (field)
        0: m_a1[sec] = sx18(data);
        1: m_a2[sec] = sx18(data);
        2: m_b1[sec] = sx18(data);
        default: m_ctrl[sec] = data & 63;
      endcase
    end
  endtask

  task automatic clear_state();
    @(negedge clk);
    state_clear = 1'b1;
    @(negedge clk);
    state_clear = 1'b0;
    model_clear();
  endtask

  // act: 0 none, 1 cfg write of A1[0], 2 stateClear pulse, 3 reset pulse,
  // applied at the act_cycle-th negedge after acceptance.
  task automatic send_sample(input int din, input int act, input int act_cycle,
                             output int got, output int lat, output bit busy_ok);
    got = 0;
    lat = -1;
    busy_ok = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 100 && !in_ready; t++) @(negedge clk);
    in_data  = 16'(din);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (out_valid) begin
        got = int'(out_data);
        lat = n;
        break;
      end
      if (n < 13 && in_ready) busy_ok = 1'b0;
      if (n == act_cycle + 1) begin
        cfg_write   = 1'b0;
        state_clear = 1'b0;
        rst_n       = 1'b1;
      end
      if (n == act_cycle) begin
        case (act)
          1: begin
            check("cfg_ready_busy", cfg_ready, 0);
            cfg_write = 1'b1;
            cfg_addr  = 6'd0;
            cfg_data  = 18'h10000;
          end
          2: state_clear = 1'b1;
          3: rst_n = 1'b0;
          default: ;
        endcase
      end
    end
  endtask

  task automatic txn(input string name, input int din, input int exp_const,
                     input bit has_const, output int got);
    int lat, mexp;
    bit busy_ok;
    model_step(din, mexp);
    send_sample(din, 0, 0, got, lat, busy_ok);
    $display("txn %s in=%0d out=%0d model=%0d lat=%0d", name, din, got, mexp, lat);
    if (has_const) check(name, got, exp_const);
    else check(name, got, mexp);
    check({name, "_latency"}, lat, 13);
    check({name, "_busy"}, busy_ok, 1);
  endtask

  task automatic setup_group(input int g);
    case (g)
      1: begin
        cfg_wr(0, 0, 0); cfg_wr(0, 1, 0); cfg_wr(0, 2, 'h08000); cfg_wr(0, 3, 0);
      end
      2: begin
        cfg_wr(0, 0, 'h38000); cfg_wr(0, 2, 0); cfg_wr(0, 3, 0);
      end
      3: cfg_wr(0, 3, 1);
      default: ;
    endcase
    clear_state();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, lat, mexp, cur_grp, din;
    bit busy_ok;

    tbl[0]  = '{0, 1000, 1000};   tbl[1]  = '{0, -32768, -32768};
    tbl[2]  = '{1, 1000, 1000};   tbl[3]  = '{1, 0, 500};
    tbl[4]  = '{1, 0, 1000};      tbl[5]  = '{1, 0, 0};       tbl[6]  = '{1, 0, 0};
    tbl[7]  = '{2, 1024, 1024};   tbl[8]  = '{2, 0, 512};
    tbl[9]  = '{2, 0, 1280};      tbl[10] = '{2, 0, 640};     tbl[11] = '{2, 0, 320};
    tbl[12] = '{3, 1024, 512};    tbl[13] = '{3, 0, 256};
    tbl[14] = '{3, 0, 640};       tbl[15] = '{3, 0, 320};     tbl[16] = '{3, 0, 160};

    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_data", out_data, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_cfg_ready", cfg_ready, 1);

    cur_grp = -1;
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].grp != cur_grp) begin
        setup_group(tbl[i].grp);
        cur_grp = tbl[i].grp;
      end
      txn($sformatf("vec%0d", i), tbl[i].din, tbl[i].exp, 1'b1, got);
    end

    // Saturation with A1 = -1: running sum clamps without wrapping.
    cfg_wr(0, 0, 'h30000); cfg_wr(0, 1, 0); cfg_wr(0, 2, 0); cfg_wr(0, 3, 0);
    clear_state();
    for (int i = 0; i < 20; i++) txn("sat_pos", 32767, 0, 1'b0, got);
    check("sat_pos_final", got, 32767);
    clear_state();
    for (int i = 0; i < 20; i++) txn("sat_neg", -32768, 0, 1'b0, got);
    check("sat_neg_final", got, -32768);

    // Coefficient write during RUN is dropped.
    cfg_wr(0, 0, 'h38000);
    clear_state();
    model_step(1024, mexp);
    send_sample(1024, 1, 5, got, lat, busy_ok);
    $display("txn gate_first in=1024 out=%0d model=%0d lat=%0d", got, mexp, lat);
    check("gate_first", got, 1024);
    check("gate_first_latency", lat, 13);
    txn("gate_next", 0, 512, 1'b1, got);

    // stateClear during RUN: current sample unaffected, next starts from zero.
    clear_state();
    txn("clr_a", 1024, 1024, 1'b1, got);
    model_step(0, mexp);
    send_sample(0, 2, 6, got, lat, busy_ok);
    $display("txn clr_mid in=0 out=%0d model=%0d lat=%0d", got, mexp, lat);
    check("clr_mid_out", got, 512);
    model_clear();
    txn("clr_b", 1024, 1024, 1'b1, got);
    txn("clr_c", 0, 512, 1'b1, got);

    // Reset during RUN: no output strobe, configuration back to bypass.
    send_sample(1000, 3, 4, got, lat, busy_ok);
    $display("txn rst_mid in=1000 out=%0d lat=%0d", got, lat);
    check("rst_no_out_valid", lat, -1);
    model_reset();
    check("rst_out_data", out_data, 0);
    for (int i = 0; i < 4; i++) begin
      din = int'($urandom_range(0, 65535)) - 32768;
      txn("post_rst_bypass", din, din, 1'b1, got);
    end

    // Randomized configuration and samples, including writes to absent sections.
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < NS + 2; s++) begin
        cfg_wr(s, 0, int'($urandom_range(0, 262143)));
        cfg_wr(s, 1, int'($urandom_range(0, 262143)));
        cfg_wr(s, 2, int'($urandom_range(0, 262143)));
        cfg_wr(s, 3, int'($urandom_range(0, 3)) | (($urandom_range(0, 3) == 0) ? 32 : 0) |
                     (($urandom_range(0, 1) == 1) ? 16 : 0));
      end
      clear_state();
      for (int i = 0; i < 10; i++) begin
        if ($urandom_range(0, 7) == 0) clear_state();
        din = int'($urandom_range(0, 65535)) - 32768;
        txn("rand", din, 0, 1'b0, got);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iir_cascade_tdm.md
# iir_cascade_tdm

Parametrised cascade of SECTIONS second-order IIR sections. All sections share one time-multiplexed multiplier, with a 3-cycle slot per section. Coefficients are run-time loadable, and samples move through a valid/ready handshake. It sits between the sample source and the FFT input buffer and replaces fixed-coefficient, one-instance-per-section cascades.

## Interface
- WORD_SIZE, 16: sample width, signed.
- ACCUM_SIZE, 24: internal accumulator width, signed.
- GUARD_BITS, 4: integer headroom bits. Input scale shift S = ACCUM_SIZE-WORD_SIZE-GUARD_BITS (4 at defaults).
- COEF_W, 18: coefficient width, signed Q2.(COEF_W-2).
- SECTIONS, 4: number of sections, legal range 1..16.
- inClock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- inData  in  WORD_SIZE  input sample.
- inValid  in  1  inData valid.
- inReady  out  1  block can accept a sample.
- outData  out  WORD_SIZE  filtered sample.
- outValid  out  1  one-cycle strobe, outData valid.
- stateClear  in  1  synchronous; zeroes all delay state.
- cfgWrite  in  1  coefficient write strobe.
- cfgAddr  in  6  {section[3:0], field[1:0]}.
- cfgData  in  COEF_W  write data.
- cfgReady  out  1  a write is accepted this cycle.

## Operation
- Per-section registers:
  - A1, A2, B1 (COEF_W each).
  - CTRL, 6 bits: {bypass, b2neg, log2gain[3:0]}. Written from cfgData[5:0].
  - Delay states w1, w2 (ACCUM_SIZE each).
- Field codes: 0 = A1, 1 = A2, 2 = B1, 3 = CTRL.
- Writes with section >= SECTIONS are ignored.
- cfgReady = (state == IDLE). cfgWrite while cfgReady = 0 is dropped.
- FSM states: IDLE -> RUN -> OUT -> IDLE.
  - IDLE: inReady = 1. inValid latches x = sext(inData) <<< S, sets k = 0, phase = 0, and moves to RUN.
  - RUN, section k, xs = x >>> log2gain(k) (arithmetic shift):
    - phase 0: acc = xs - A1·w1.
    - phase 1: w = sat(acc - A2·w2).
    - phase 2: y = sat(w + B1·w1 ± w2), with minus when b2neg = 1. Then w2 <= w1, w1 <= w, x <= y.
    - After phase 2 of section SECTIONS-1, go to OUT.
  - Bypass section: still uses its 3 cycles. x is unchanged and w1, w2 are not updated.
  - OUT: outData <= sat_WORD(round(x)), outValid = 1 for one cycle, then IDLE.
- Arithmetic:
  - Products are full width (COEF_W+ACCUM_SIZE), then arithmetic-shifted right by COEF_W-2 (truncation toward -inf).
  - Sums are formed in ACCUM_SIZE+2 bits and saturated to ACCUM_SIZE at w and at y only. acc is not saturated.
  - Output: add 2^(S-1), shift right by S, then saturate to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1].
- stateClear:
  - In IDLE: all w1, w2 cleared; coefficients are kept.
  - In RUN/OUT: takes effect on entry to IDLE. The sample in flight completes with old state, and its state update is discarded.
- stateClear and inValid in the same IDLE cycle: clear is applied first, and the sample is accepted against zero state.
- Reset:
  - FSM to IDLE; outData = 0, outValid = 0, inReady = 1 after release, cfgReady = 1.
  - All w = 0, A1 = A2 = B1 = 0, CTRL = 6'b100000 (bypass, gain 0).
  - Reset mid-RUN aborts the sample: no outValid is produced.

## Timing
- Sample accepted at edge t0 (inValid & inReady).
- RUN occupies edges t0+1 .. t0+3·SECTIONS.
- outValid is high in the cycle after edge t0+3·SECTIONS+1. Latency L = 3·SECTIONS+1 edges (13 at defaults).
- inReady is low from t0+1 until OUT has completed. Maximum throughput is one sample per 3·SECTIONS+2 cycles.
- inValid while inReady = 0 is ignored. The source must hold it; no data is buffered.
- A cfgWrite accepted at edge t applies to the first sample accepted at edge t+1 or later.

## Test plan
- Reset defaults, all sections bypassed:
  - inData = 1000, then -32768 -> outputs 1000, then -32768.
  - outValid arrives exactly 13 cycles after acceptance; inReady is low throughout.
- Section 0 FIR check, bypass = 0, gain 0, A1 = A2 = 0, B1 = 0x08000, b2neg = 0:
  - impulse 1000 then zeros -> 1000, 500, 1000, 0, 0.
- Section 0 recursion, A1 = 0x38000 (-0.5), A2 = 0, B1 = 0, b2neg = 0:
  - impulse 1024 -> 1024, 512, 1280, 640, 320.
  - Same run with log2gain = 1 -> all values halved.
- Saturation, A1 = 0x30000 (-1):
  - step 32767 held -> output climbs, then clamps at 32767 with no wrap.
  - step -32768 -> clamps at -32768.
- Config gating: cfgWrite A1 issued mid-RUN -> dropped (cfgReady = 0), and the next output matches the old coefficients.
- Reset and clear:
  - stateClear pulsed mid-RUN -> current output unaffected; the next impulse response restarts from zero state.
  - reset asserted mid-RUN -> no outValid; all CTRL registers read back as bypass.
